io_port_unit: RTL and testbench

Parametrised I/O and interrupt front-end that sits between the processor core and its external pins. It generalises the single 16-bit inputPort/outputPort/interrupt trio into configurable-width ports. It adds an input FIFO with strobe handshake, a registered output port and an acknowledged interrupt-request FSM. The core's IN instruction pops the FIFO, OUT writes the output register, and the interrupt line is exposed as a level request cleared by acknowledge.

---
 rtl/io_pkg.sv | 14 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/io_port_unit.sv | 104 ++++++++++
 tb/tb_io_port_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the I/O port unit.
//   irq_state_t    : interrupt request FSM states
//   DEFAULT_DATA_W : default port data width
package io_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IrqIdle,
    IrqPending,
    IrqService
  } irq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with synchronous active-high reset.
//   clk, rst     : clock, synchronous reset (clears pointers/count)
//   push, wdata  : write strobe and data (caller guarantees !full or pop)
//   pop          : read strobe (caller guarantees !empty)
//   head         : current head entry, 0 when empty
//   full, empty  : occupancy flags
module sync_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem[rd_ptr_q];

  // Pointers are PtrW bits wide, so increment wraps modulo FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_port_unit.sv
// I/O and interrupt front-end between the core and external pins.
//   clk, rst            : clock, synchronous active-high reset
//   start               : run enable; gates input sampling and new IRQs
//   in_data, in_strobe  : external input word and its strobe
//   in_ready            : input FIFO can accept this cycle
//   rd_en, rd_data      : core IN: pop FIFO head (show-ahead, 0 when empty)
//   rd_empty            : FIFO empty
//   out_we, out_wdata   : core OUT: write output register
//   out_port            : registered output port
//   ext_int             : asynchronous interrupt pin
//   irq, irq_ack        : interrupt request and acknowledge
//   overflow            : sticky, a strobe was dropped while full
module io_port_unit
  import io_pkg::*;
#(
  parameter int unsigned       DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned       FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] OUT_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_strobe,
  output logic              in_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_empty,
  input  logic              out_we,
  input  logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0] out_port,
  input  logic              ext_int,
  output logic              irq,
  input  logic              irq_ack,
  output logic              overflow
);

  logic push, pop, full, empty;

  assign pop      = rd_en & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign in_ready = ~full | pop;
  assign push     = in_strobe & start & in_ready;
  assign rd_empty = empty;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .head  (rd_data),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_port <= OUT_RST_VAL;
      overflow <= 1'b0;
    end else begin
      if (out_we) out_port <= out_wdata;
      if (in_strobe && start && !in_ready) overflow <= 1'b1;
    end
  end

  // Interrupt path: two-flop synchroniser, previous-value flop, rising-edge detect.
  logic       sync1_q, sync2_q, prev_q, int_edge;
  irq_state_t state_q, state_d;

  assign int_edge = sync2_q & ~prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= IrqIdle;
      irq     <= 1'b0;
    end else begin
      sync1_q <= ext_int;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      // Drop the request the cycle after it is acknowledged.
      irq     <= (state_q == IrqPending) & ~irq_ack;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IrqIdle:    if (int_edge && start) state_d = IrqPending;
      IrqPending: if (irq_ack)           state_d = IrqService;
      // Pin must be released before the request can re-arm.
      IrqService: if (!sync2_q)          state_d = IrqIdle;
      default:                           state_d = IrqIdle;
    endcase
  end

endmodule

// File: tb/tb_io_port_unit.sv
module tb_io_port_unit;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst, start, in_strobe, rd_en, out_we, ext_int, irq_ack;
  logic [W-1:0] in_data, out_wdata;
  logic         in_ready, rd_empty, irq, overflow;
  logic [W-1:0] rd_data, out_port;

  always #5 clk = ~clk;

  io_port_unit #(
    .DATA_W      (W),
    .FIFO_DEPTH  (D),
    .OUT_RST_VAL (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .in_ready  (in_ready),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_empty  (rd_empty),
    .out_we    (out_we),
    .out_wdata (out_wdata),
    .out_port  (out_port),
    .ext_int   (ext_int),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic         empty;
    logic [W-1:0] data;
    logic         ready;
    logic [W-1:0] outp;
    logic         irq;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failures = 0;

  // Reference model
  logic [W-1:0] m_fifo[$];
  logic [W-1:0] m_out;
  logic         m_ovf, m_irq;
  // Pin value as seen at the last three edges: pin_hist[0] newest.
  logic [2:0]   pin_hist;
  int           m_phase; // 0 waiting, 1 requesting, 2 being serviced

  task automatic check1(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check1("rd_empty", W'(rd_empty), W'(e.empty));
        check1("rd_data",  rd_data,      e.data);
        check1("in_ready", W'(in_ready), W'(e.ready));
        check1("out_port", out_port,     e.outp);
        check1("irq",      W'(irq),      W'(e.irq));
        check1("overflow", W'(overflow), W'(e.ovf));
      end
    end
  end

  task automatic step(input logic r, input logic st, input logic stb, input logic [W-1:0] d,
                      input logic rd, input logic we, input logic [W-1:0] wd,
                      input logic ext, input logic ack);
    exp_t e;
    bit   pop_ok, room, rise_seen;
    @(negedge clk);
    rst = r; start = st; in_strobe = stb; in_data = d; rd_en = rd;
    out_we = we; out_wdata = wd; ext_int = ext; irq_ack = ack;
    if (r) begin
      m_fifo.delete();
      m_out = '0; m_ovf = 1'b0; m_irq = 1'b0; pin_hist = '0; m_phase = 0;
    end else begin
      pop_ok = rd && (m_fifo.size() > 0);
      room   = (m_fifo.size() < D) || pop_ok;
      if (stb && st && !room) m_ovf = 1'b1;
      if (pop_ok) void'(m_fifo.pop_front());
      if (stb && st && room) m_fifo.push_back(d);
      if (we) m_out = wd;
      // Synchronised pin rose: high two edges ago, low three edges ago.
      rise_seen = pin_hist[1] && !pin_hist[2];
      m_irq = (m_phase == 1) && !ack;
      case (m_phase)
        0: if (rise_seen && st) m_phase = 1;
        1: if (ack) m_phase = 2;
        default: if (!pin_hist[1]) m_phase = 0;
      endcase
      pin_hist = {pin_hist[1:0], ext};
    end
    e.empty = (m_fifo.size() == 0);
    e.data  = e.empty ? '0 : m_fifo[0];
    e.ready = (m_fifo.size() < D) || (rd && m_fifo.size() > 0);
    e.outp  = m_out;
    e.irq   = m_irq;
    e.ovf   = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic st, input logic ext);
    step(1'b0, st, 1'b0, '0, 1'b0, 1'b0, '0, ext, 1'b0);
  endtask

  initial begin
    logic [W-1:0] vals[5];
    logic         ext_r, st_r;
    rst = 1'b1; start = 1'b0; in_strobe = 1'b0; in_data = '0; rd_en = 1'b0;
    out_we = 1'b0; out_wdata = '0; ext_int = 1'b0; irq_ack = 1'b0;
    m_fifo.delete(); m_out = '0; m_ovf = 1'b0; m_irq = 1'b0; pin_hist = '0; m_phase = 0;

    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Single push then pop
    step(1'b0, 1'b1, 1'b1, 16'h0030, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);

    // Fill, overflow, drain
    vals[0] = 16'h0040; vals[1] = 16'h0500; vals[2] = 16'h0100;
    vals[3] = 16'h07FF; vals[4] = 16'h1234;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, vals[i], 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0); // read while empty

    // Clear overflow, fill, then push+pop while full
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, vals[i], 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'hF320, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Interrupt: raise, ack, held high (no re-arm), release, raise again
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);

    // Output write with start low, then reset mid-stream
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

    // start low: strobes and pin edges ignored
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b0, 1'b1, W'(i * 17), 1'b0, 1'b0, '0, logic'(i[1]), 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Randomised traffic
    ext_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) ext_r = ~ext_r;
      st_r = ($urandom_range(7) != 0);
      step(($urandom_range(199) == 0), st_r, logic'($urandom_range(1)), W'($urandom),
           ($urandom_range(2) == 0), ($urandom_range(7) == 0), W'($urandom), ext_r,
           m_irq ? logic'($urandom_range(1)) : ($urandom_range(15) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
